// File: rtl/mem_pkg.sv
// mem_pkg: types and default widths shared by the data cache, MMU and the
// store buffer.
//   store_buf_state_e : store buffer FSM states (IDLE, WRITE, READ, FWD)
//   mem_entry_t       : one posted store, {addr, data}, at the default widths
//   ADDR_W_DEF/DATA_W_DEF : default address/data widths
package mem_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      FWD   = 2'd3
   } store_buf_state_e;

   typedef struct packed {
      logic [ADDR_W_DEF-1:0] addr;
      logic [DATA_W_DEF-1:0] data;
   } mem_entry_t;

endpackage

// File: rtl/store_buf_fifo.sv
// store_buf_fifo: storage for posted stores ({addr, data} per entry).
// Optional macro: STORE_BUF_FWD_EN adds a per-entry read port (head pointer,
// occupancy and the raw entry arrays) for the forwarding search.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   push, push_addr/data  enqueue request (ignored while full)
//   pop                   dequeue request (ignored while empty)
//   head_addr/head_data   oldest entry
//   full                  registered, count == DEPTH
//   empty                 count == 0
//   head, count, entry_*  forwarding read port (STORE_BUF_FWD_EN only)
module store_buf_fifo import mem_pkg::*; #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [ADDR_W-1:0] push_addr,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [ADDR_W-1:0] head_addr,
   output logic [DATA_W-1:0] head_data,
   output logic              full,
   output logic              empty
`ifdef STORE_BUF_FWD_EN
   ,
   output logic [PTR_W-1:0]  head,
   output logic [CNT_W-1:0]  count,
   output logic [ADDR_W-1:0] entry_addr [DEPTH],
   output logic [DATA_W-1:0] entry_data [DEPTH]
`endif
);

   logic [ADDR_W-1:0] addr_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [PTR_W-1:0]  head_q, tail_q;
   logic [CNT_W-1:0]  count_q, count_n;
   logic              full_q;
   logic              do_push, do_pop;

   assign do_push = push && !full_q;
   assign do_pop  = pop && (count_q != '0);

   always_comb begin
      count_n = count_q;
      if (do_push && !do_pop)
         count_n = count_q + 1'b1;
      else if (!do_push && do_pop)
         count_n = count_q - 1'b1;
   end

   // full is registered from the next count, so a pop while full only
   // lowers it after the popping edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
      end else begin
         if (do_push) tail_q <= tail_q + 1'b1;
         if (do_pop)  head_q <= head_q + 1'b1;
         count_q <= count_n;
         full_q  <= (count_n == CNT_W'(DEPTH));
      end
   end

   // Entry contents need no reset: occupancy decides what is valid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         addr_mem[tail_q] <= push_addr;
         data_mem[tail_q] <= push_data;
      end
   end

   assign head_addr = addr_mem[head_q];
   assign head_data = data_mem[head_q];
   assign full      = full_q;
   assign empty     = (count_q == '0);

`ifdef STORE_BUF_FWD_EN
   assign head       = head_q;
   assign count      = count_q;
   assign entry_addr = addr_mem;
   assign entry_data = data_mem;
`endif

endmodule

// File: rtl/store_buffer.sv
// store_buffer: posted-write buffer between the data cache and memory.
// Stores are queued and drained in order over mem_req/mem_ack; miss reads
// wait until every earlier store has reached memory.
// Optional macro: STORE_BUF_FWD_EN lets a miss read be answered from the
// youngest queued store to the same address, without a memory read.
// Handshake: mem_req rises with mem_we/mem_addr/mem_wdata and all of them
// stay constant until the cycle mem_ack is high; the transaction completes
// on that edge and mem_req drops. mem_ack while no request is up is ignored.
// Ports:
//   wr_valid/wr_ready/wr_addr/wr_data  store intake (push on valid && ready)
//   rd_valid/rd_addr                   miss read, held until rd_done
//   rd_done/rd_data                    one-cycle completion pulse + data
//   mem_*                              memory transaction port
//   empty                              no store pending
module store_buffer import mem_pkg::*; #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_valid,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_done,
   output logic [DATA_W-1:0] rd_data,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              empty
);

   store_buf_state_e  state_q, state_n;
   logic              req_n, we_n, rd_done_n, pop;
   logic [ADDR_W-1:0] addr_n, head_addr;
   logic [DATA_W-1:0] wdata_n, rd_data_n, head_data;
   logic              full, fifo_empty;

`ifdef STORE_BUF_FWD_EN
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   logic [PTR_W-1:0]  fifo_head, idx;
   logic [CNT_W-1:0]  fifo_count;
   logic [ADDR_W-1:0] entry_addr [DEPTH];
   logic [DATA_W-1:0] entry_data [DEPTH];
   logic              fwd_hit;
   logic [DATA_W-1:0] fwd_data;
`endif

   store_buf_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (wr_valid),
      .push_addr (wr_addr),
      .push_data (wr_data),
      .pop       (pop),
      .head_addr (head_addr),
      .head_data (head_data),
      .full      (full),
      .empty     (fifo_empty)
`ifdef STORE_BUF_FWD_EN
      ,
      .head       (fifo_head),
      .count      (fifo_count),
      .entry_addr (entry_addr),
      .entry_data (entry_data)
`endif
   );

   assign wr_ready = !full;
   assign empty    = fifo_empty;

`ifdef STORE_BUF_FWD_EN
   // Walk from the head towards the tail; a later match overrides an earlier
   // one, so the result is the youngest matching store.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      idx      = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = fifo_head + PTR_W'(k);
         if ((CNT_W'(k) < fifo_count) && (entry_addr[idx] == rd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = entry_data[idx];
         end
      end
   end
`endif

   // A read is not (re)started while rd_done is high: the cache still holds
   // rd_valid during that cycle for the read that just completed.
   always_comb begin
      state_n   = state_q;
      req_n     = mem_req;
      we_n      = mem_we;
      addr_n    = mem_addr;
      wdata_n   = mem_wdata;
      rd_done_n = 1'b0;
      rd_data_n = rd_data;
      pop       = 1'b0;
      case (state_q)
         IDLE: begin
`ifdef STORE_BUF_FWD_EN
            if (rd_valid && !rd_done && fwd_hit)
               state_n = FWD;
            else
`endif
            if (!fifo_empty) begin
               state_n = WRITE;
               req_n   = 1'b1;
               we_n    = 1'b1;
               addr_n  = head_addr;
               wdata_n = head_data;
            end else if (rd_valid && !rd_done) begin
               state_n = READ;
               req_n   = 1'b1;
               we_n    = 1'b0;
               addr_n  = rd_addr;
            end
         end
         WRITE: begin
            if (mem_ack) begin
               pop     = 1'b1;
               req_n   = 1'b0;
               state_n = IDLE;
            end
         end
         READ: begin
            if (mem_ack) begin
               rd_data_n = mem_rdata;
               rd_done_n = 1'b1;
               req_n     = 1'b0;
               state_n   = IDLE;
            end
         end
         FWD: begin
`ifdef STORE_BUF_FWD_EN
            rd_data_n = fwd_data;
            rd_done_n = 1'b1;
`endif
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rd_done   <= 1'b0;
         rd_data   <= '0;
      end else begin
         state_q   <= state_n;
         mem_req   <= req_n;
         mem_we    <= we_n;
         mem_addr  <= addr_n;
         mem_wdata <= wdata_n;
         rd_done   <= rd_done_n;
         rd_data   <= rd_data_n;
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed bench for store_buffer. Expected memory
// transactions and read completions are queued by the stimulus; a monitor
// pops and compares them whenever the DUT completes one.
module tb_store_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_valid, wr_ready;
   logic [31:0] wr_addr, wr_data;
   logic        rd_valid;
   logic [31:0] rd_addr;
   logic        rd_done;
   logic [31:0] rd_data;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        empty;

   store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_valid  (rd_valid),
      .rd_addr   (rd_addr),
      .rd_done   (rd_done),
      .rd_data   (rd_data),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .empty     (empty)
   );

   // ---------------- clock / reset / counters ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_pass = 0;

   // {we, addr, data}; data is ignored for reads
   logic [64:0] exp_q [$];
   logic [31:0] rd_exp_q [$];
   logic [64:0] e;

   // memory responder controls
   logic        ack_en    = 1'b0;
   int          ack_delay = 0;
   int          wait_cnt  = 0;
   logic [31:0] rdata_val = 32'h0;

   // inter-transaction gap monitor
   logic gap_chk  = 1'b0;
   int   last_ack = -1;
   logic req_prev = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- driver tasks ----------------
   // Called just after a rising edge; returns just after the next one.
   task automatic push_one(input logic [31:0] a, input logic [31:0] d, input bit expect_write);
      wr_valid = 1'b1;
      wr_addr  = a;
      wr_data  = d;
      if (expect_write) exp_q.push_back({1'b1, a, d});
      @(posedge clk); #1;
      wr_valid = 1'b0;
   endtask

   task automatic wait_empty(input int budget, input string name);
      bit ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (empty && !mem_req) begin ok = 1; break; end
      end
      chk({name, "_drain"}, 64'(ok), 64'd1);
   endtask

   task automatic wait_rd_done(input int budget, input string name);
      bit ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (rd_done) begin ok = 1; break; end
      end
      chk({name, "_rd_done_seen"}, 64'(ok), 64'd1);
   endtask

   // ---------------- memory responder ----------------
   initial begin
      forever begin
         @(posedge clk); #1;
         if (ack_en) begin
            mem_ack   = 1'b0;
            mem_rdata = rdata_val;
            if (!mem_req) wait_cnt = 0;
            else if (wait_cnt >= ack_delay) begin
               mem_ack  = 1'b1;
               wait_cnt = 0;
            end else wait_cnt++;
         end
      end
   end

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (!rst) begin
         if (mem_req && !req_prev && gap_chk && last_ack >= 0)
            chk("gap_between_reqs", 64'(cyc - last_ack), 64'd2);
         if (mem_req && mem_ack) begin
            last_ack = cyc;
            if (exp_q.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_txn: we=%0d addr=%0h wdata=%0h, none expected", mem_we, mem_addr, mem_wdata);
            end else begin
               e = exp_q.pop_front();
               chk("txn_we", 64'(mem_we), 64'(e[64]));
               chk("txn_addr", 64'(mem_addr), 64'(e[63:32]));
               if (e[64]) chk("txn_wdata", 64'(mem_wdata), 64'(e[31:0]));
               else       chk("read_only_when_empty", 64'(empty), 64'd1);
            end
         end
         if (rd_done) begin
            if (rd_exp_q.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_rd_done: rd_data=%0h, none expected", rd_data);
            end else begin
               chk("rd_data", 64'(rd_data), 64'(rd_exp_q.pop_front()));
            end
         end
      end
      req_prev = mem_req;
   end

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed stimulus ----------------
   initial begin
      rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
      rd_valid = 1'b0; rd_addr = '0; mem_ack = 1'b0; mem_rdata = '0;
      repeat (3) @(posedge clk); #1;
      rst = 1'b0;

      // 1: idle after reset
      repeat (10) begin
         @(negedge clk);
         chk("rst_wr_ready", 64'(wr_ready), 64'd1);
         chk("rst_empty", 64'(empty), 64'd1);
         chk("rst_mem_req", 64'(mem_req), 64'd0);
      end
      chk("rst_rd_done", 64'(rd_done), 64'd0);
      chk("rst_rd_data", 64'(rd_data), 64'd0);
      chk("rst_mem_we", 64'(mem_we), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
      chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);

      // 2: fill with memory stalled, then drain in order
      @(posedge clk); #1;
      push_one(32'h10, 32'hA, 1);
      push_one(32'h14, 32'hB, 1);
      push_one(32'h18, 32'hC, 1);
      push_one(32'h1C, 32'hD, 1);
      @(negedge clk);
      chk("full_wr_ready", 64'(wr_ready), 64'd0);
      chk("full_empty", 64'(empty), 64'd0);
      chk("stall_mem_req", 64'(mem_req), 64'd1);
      chk("stall_mem_we", 64'(mem_we), 64'd1);
      chk("stall_mem_addr", 64'(mem_addr), 64'h10);
      chk("stall_mem_wdata", 64'(mem_wdata), 64'hA);
      last_ack  = -1;
      gap_chk   = 1'b1;
      ack_delay = 2;
      ack_en    = 1'b1;
      wait_empty(200, "fill4");
      gap_chk = 1'b0;
      chk("fill4_empty", 64'(empty), 64'd1);

      // 3: read waits behind a pending store
      ack_en = 1'b0;
      rdata_val = 32'h1234;
      @(posedge clk); #1;
      push_one(32'h20, 32'h55, 1);
      rd_valid = 1'b1;
      rd_addr  = 32'h40;
      exp_q.push_back({1'b1, 32'h40, 32'h0} & {1'b0, {64{1'b1}}});
      rd_exp_q.push_back(32'h1234);
      repeat (5) @(negedge clk);
      chk("rd_blocked_req", 64'(mem_req), 64'd1);
      chk("rd_blocked_we", 64'(mem_we), 64'd1);
      chk("rd_blocked_addr", 64'(mem_addr), 64'h20);
      ack_delay = 1;
      ack_en    = 1'b1;
      wait_rd_done(100, "rd_behind_wr");
      @(posedge clk); #1;
      rd_valid = 1'b0;
      wait_empty(50, "rd_behind_wr");
      repeat (5) begin
         @(negedge clk);
         chk("no_extra_read", 64'(mem_req), 64'd0);
      end

`ifdef STORE_BUF_FWD_EN
      // 4: forward from the youngest matching store
      ack_en = 1'b0;
      @(posedge clk); #1;
      push_one(32'h30, 32'h1, 1);
      push_one(32'h30, 32'h2, 1);
      rd_valid = 1'b1;
      rd_addr  = 32'h30;
      rd_exp_q.push_back(32'h2);
      @(negedge clk);
      ack_delay = 1;
      ack_en    = 1'b1;
      wait_rd_done(100, "fwd");
      @(posedge clk); #1;
      rd_valid = 1'b0;
      wait_empty(100, "fwd");
`endif

      // 5: full, push and ack in the same cycle
      ack_en  = 1'b0;
      mem_ack = 1'b0;
      @(posedge clk); #1;
      push_one(32'h50, 32'h21, 1);
      push_one(32'h54, 32'h22, 1);
      push_one(32'h58, 32'h23, 1);
      push_one(32'h5C, 32'h24, 1);
      @(negedge clk);
      chk("full2_wr_ready", 64'(wr_ready), 64'd0);
      @(posedge clk); #1;
      wr_valid = 1'b1; wr_addr = 32'h60; wr_data = 32'h99;   // must be ignored
      mem_ack  = 1'b1;
      @(negedge clk);
      chk("pop_cycle_wr_ready", 64'(wr_ready), 64'd0);
      @(posedge clk); #1;
      wr_valid = 1'b0;
      mem_ack  = 1'b0;
      @(negedge clk);
      chk("after_pop_wr_ready", 64'(wr_ready), 64'd1);
      chk("after_pop_mem_req", 64'(mem_req), 64'd0);
      @(posedge clk); #1;
      push_one(32'h60, 32'h99, 1);
      @(negedge clk);
      chk("refill_wr_ready", 64'(wr_ready), 64'd0);
      ack_delay = 0;
      ack_en    = 1'b1;
      wait_empty(200, "full_push_pop");

      // 6: reset in the middle of a write
      ack_en = 1'b0;
      @(posedge clk); #1;
      push_one(32'h70, 32'h77, 0);
      repeat (2) @(negedge clk);
      chk("pre_rst_mem_req", 64'(mem_req), 64'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("async_rst_mem_req", 64'(mem_req), 64'd0);
      chk("async_rst_empty", 64'(empty), 64'd1);
      chk("async_rst_wr_ready", 64'(wr_ready), 64'd1);
      @(negedge clk);
      rst    = 1'b0;
      ack_en = 1'b1;
      repeat (10) @(negedge clk);
      chk("post_rst_mem_req", 64'(mem_req), 64'd0);
      chk("post_rst_empty", 64'(empty), 64'd1);

      chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
      chk("rd_exp_q_drained", 64'(rd_exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
